// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 line port between I-cache and D-cache.
// Single transaction in flight; all outputs registered.
module l2_port_arbiter #(
  parameter int ADDR_W = 26,
  parameter int LINE_W = 512,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_add,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_add,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [LINE_W-1:0] d_rdata,
  output logic              l2_req,
  output logic              l2_wr,
  output logic [ADDR_W-1:0] l2_add,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_ack,
  input  logic              l2_rvalid,
  input  logic [LINE_W-1:0] l2_rdata,
  output logic [CNT_W-1:0]  i_grants,
  output logic [CNT_W-1:0]  d_grants,
  output logic              proto_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state_q, state_d;
  logic                last_d_q, last_d_d;   // 1: D owns / owned the port last
  logic                pick_d;
  logic                i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic                i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic                l2_req_q, l2_req_d, l2_wr_q, l2_wr_d;
  logic [ADDR_W-1:0]   l2_add_q, l2_add_d;
  logic [LINE_W-1:0]   l2_wdata_q, l2_wdata_d;
  logic [CNT_W-1:0]    i_grants_q, i_grants_d, d_grants_q, d_grants_d;
  logic                proto_err_q, proto_err_d;

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    pick_d      = 1'b0;
    i_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    i_rvalid_d  = 1'b0;
    d_rvalid_d  = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    l2_req_d    = l2_req_q;
    l2_wr_d     = l2_wr_q;
    l2_add_d    = l2_add_q;
    l2_wdata_d  = l2_wdata_q;
    i_grants_d  = i_grants_q;
    d_grants_d  = d_grants_q;
    // A response is only legal while waiting for read data
    proto_err_d = proto_err_q | (l2_rvalid & (state_q != WAIT));
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          pick_d     = d_req & (~i_req | ~last_d_q);
          last_d_d   = pick_d;
          state_d    = ISSUE;
          l2_req_d   = 1'b1;
          l2_add_d   = pick_d ? d_add : i_add;
          l2_wr_d    = pick_d & d_wr;
          l2_wdata_d = (pick_d & d_wr) ? d_wdata : '0;
          if (pick_d) begin
            d_gnt_d    = 1'b1;
            d_grants_d = d_grants_q + CNT_W'(1);
          end else begin
            i_gnt_d    = 1'b1;
            i_grants_d = i_grants_q + CNT_W'(1);
          end
        end
      end
      ISSUE: begin
        if (l2_ack) begin
          l2_req_d = 1'b0;
          state_d  = l2_wr_q ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (l2_rvalid) begin
          state_d = IDLE;
          if (last_d_q) begin
            d_rdata_d  = l2_rdata;
            d_rvalid_d = 1'b1;
          end else begin
            i_rdata_d  = l2_rdata;
            i_rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      l2_req_q    <= 1'b0;
      l2_wr_q     <= 1'b0;
      l2_add_q    <= '0;
      l2_wdata_q  <= '0;
      i_grants_q  <= '0;
      d_grants_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      i_gnt_q     <= i_gnt_d;
      d_gnt_q     <= d_gnt_d;
      i_rvalid_q  <= i_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      l2_req_q    <= l2_req_d;
      l2_wr_q     <= l2_wr_d;
      l2_add_q    <= l2_add_d;
      l2_wdata_q  <= l2_wdata_d;
      i_grants_q  <= i_grants_d;
      d_grants_q  <= d_grants_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign i_rvalid  = i_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign l2_req    = l2_req_q;
  assign l2_wr     = l2_wr_q;
  assign l2_add    = l2_add_q;
  assign l2_wdata  = l2_wdata_q;
  assign i_grants  = i_grants_q;
  assign d_grants  = d_grants_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: one task per scenario, inline checks.
module tb_l2_port_arbiter;
  localparam int ADDR_W = 26;
  localparam int LINE_W = 512;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              clear;
  logic              i_req, d_req, d_wr;
  logic [ADDR_W-1:0] i_add, d_add;
  logic [LINE_W-1:0] d_wdata, l2_rdata;
  logic              l2_ack, l2_rvalid;
  logic              i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [LINE_W-1:0] i_rdata, d_rdata, l2_wdata;
  logic              l2_req, l2_wr, proto_err;
  logic [ADDR_W-1:0] l2_add;
  logic [CNT_W-1:0]  i_grants, d_grants;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  localparam logic [LINE_W-1:0] LINE2  = {16{32'hDEADBEEF}};
  localparam logic [LINE_W-1:0] LINE3  = {16{32'h3C3C_0001}};
  localparam logic [LINE_W-1:0] LINE5  = {16{32'h5555_1234}};
  localparam logic [LINE_W-1:0] LINE5B = {16{32'hA5A5_0F0F}};

  always #5 clk = ~clk;

  l2_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .clear(clear),
    .i_req(i_req), .i_add(i_add), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_add(d_add), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .l2_req(l2_req), .l2_wr(l2_wr), .l2_add(l2_add), .l2_wdata(l2_wdata),
    .l2_ack(l2_ack), .l2_rvalid(l2_rvalid), .l2_rdata(l2_rdata),
    .i_grants(i_grants), .d_grants(d_grants), .proto_err(proto_err)
  );

  function automatic bit outs_zero();
    return ({i_gnt, i_rvalid, d_gnt, d_rvalid, l2_req, l2_wr, proto_err} === 7'b0) &&
           (i_rdata === '0) && (d_rdata === '0) && (l2_add === '0) &&
           (l2_wdata === '0) && (i_grants === '0) && (d_grants === '0);
  endfunction

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    i_req = 0; d_req = 0; d_wr = 0; i_add = '0; d_add = '0; d_wdata = '0;
    l2_ack = 0; l2_rvalid = 0; l2_rdata = '0;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    tot_cnt++;
    if (!outs_zero()) $display("FAIL reset_outputs: got nonzero outputs, want all 0");
    else pass_cnt++;
  endtask

  task automatic test_i_read();
    i_req = 1; i_add = 26'h0ABCDEF;
    @(negedge clk);
    tot_cnt++;
    if ({i_gnt, d_gnt, l2_req, l2_wr} !== 4'b1010 || l2_add !== 26'h0ABCDEF)
      $display("FAIL i_read_grant: gnt/dgnt/req/wr=%b add=%h want 1010 0abcdef",
               {i_gnt, d_gnt, l2_req, l2_wr}, l2_add);
    else pass_cnt++;
    i_req = 0; l2_ack = 1;
    @(negedge clk);
    tot_cnt++;
    if ({i_gnt, l2_req, i_rvalid} !== 3'b000)
      $display("FAIL i_read_ack: gnt/req/rvalid=%b want 000", {i_gnt, l2_req, i_rvalid});
    else pass_cnt++;
    l2_ack = 0; l2_rvalid = 1; l2_rdata = LINE2;
    @(negedge clk);
    l2_rvalid = 0;
    tot_cnt++;
    if (i_rvalid !== 1'b1 || i_rdata !== LINE2 || i_grants !== 32'd1 || d_rvalid !== 1'b0)
      $display("FAIL i_read_data: rvalid=%b grants=%0d rdata[31:0]=%h want 1 1 deadbeef",
               i_rvalid, i_grants, i_rdata[31:0]);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if (i_rvalid !== 1'b0 || proto_err !== 1'b0)
      $display("FAIL i_read_pulse: rvalid=%b proto_err=%b want 0 0", i_rvalid, proto_err);
    else pass_cnt++;
  endtask

  task automatic test_alternation();
    int  ng = 0;
    bit  flag = 0;
    bit  exp_i;
    pulse_clear();
    l2_rdata = LINE3; d_wr = 0; d_add = 26'h0000123; i_add = 26'h0000456;
    i_req = 1; d_req = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (i_gnt || d_gnt) begin
        exp_i = (ng % 2 == 0);
        tot_cnt++;
        if (i_gnt !== exp_i || d_gnt !== !exp_i)
          $display("FAIL alt_order%0d: i_gnt=%b d_gnt=%b want i_gnt=%b", ng, i_gnt, d_gnt, exp_i);
        else pass_cnt++;
        ng++;
        if (ng == 6) begin i_req = 0; d_req = 0; end
      end
      l2_rvalid = flag;
      flag      = l2_req;
      l2_ack    = l2_req;
    end
    l2_ack = 0; l2_rvalid = 0;
    tot_cnt++;
    if (ng != 6 || i_grants !== 32'd3 || d_grants !== 32'd3)
      $display("FAIL alt_counts: grants seen=%0d i=%0d d=%0d want 6 3 3", ng, i_grants, d_grants);
    else pass_cnt++;
    tot_cnt++;
    if (d_rdata !== LINE3 || i_rdata !== LINE3 || proto_err !== 1'b0)
      $display("FAIL alt_data: d=%h i=%h perr=%b want 3c3c0001 x2, 0",
               d_rdata[31:0], i_rdata[31:0], proto_err);
    else pass_cnt++;
  endtask

  task automatic test_writeback();
    bit stable = 1;
    bit saw_rv = 0;
    d_req = 1; d_wr = 1; d_add = 26'h1234567; d_wdata = '1;
    @(negedge clk);
    saw_rv |= d_rvalid;
    tot_cnt++;
    if (d_gnt !== 1'b1 || l2_req !== 1'b1 || l2_wr !== 1'b1 || l2_add !== 26'h1234567)
      $display("FAIL wb_grant: gnt=%b req=%b wr=%b add=%h want 1 1 1 1234567",
               d_gnt, l2_req, l2_wr, l2_add);
    else pass_cnt++;
    d_req = 0; d_wdata = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      saw_rv |= d_rvalid;
      if (l2_req !== 1'b1 || l2_wr !== 1'b1 || l2_wdata !== {LINE_W{1'b1}} ||
          l2_add !== 26'h1234567 || d_gnt !== 1'b0) stable = 0;
      if (k == 4) l2_ack = 1;
    end
    tot_cnt++;
    if (!stable) $display("FAIL wb_stable: l2 request changed while ack low, want held");
    else pass_cnt++;
    @(negedge clk);
    l2_ack = 0;
    saw_rv |= d_rvalid;
    tot_cnt++;
    if (l2_req !== 1'b0 || d_grants !== 32'd4)
      $display("FAIL wb_done: req=%b d_grants=%0d want 0 4", l2_req, d_grants);
    else pass_cnt++;
    repeat (2) begin @(negedge clk); saw_rv |= d_rvalid; end
    tot_cnt++;
    if (saw_rv || d_rdata !== LINE3)
      $display("FAIL wb_no_rvalid: saw d_rvalid=%b d_rdata=%h want 0 3c3c0001", saw_rv, d_rdata[31:0]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    i_req = 1; i_add = 26'h0000777; l2_rdata = LINE5;
    @(negedge clk);
    tot_cnt++;
    if (i_gnt !== 1'b1) $display("FAIL b2b_igrant: i_gnt=%b want 1", i_gnt);
    else pass_cnt++;
    i_req = 0; l2_ack = 1;
    @(negedge clk);
    l2_ack = 0; d_req = 1; d_wr = 0; d_add = 26'h0000888;
    @(negedge clk);
    tot_cnt++;
    if (d_gnt !== 1'b0) $display("FAIL b2b_wait_nogrant: d_gnt=%b want 0", d_gnt);
    else pass_cnt++;
    l2_rvalid = 1;
    @(negedge clk);
    l2_rvalid = 0;
    tot_cnt++;
    if (i_rvalid !== 1'b1 || i_rdata !== LINE5 || d_rdata !== LINE3 || d_gnt !== 1'b0)
      $display("FAIL b2b_iresp: rv=%b i=%h d=%h gnt=%b want 1 55551234 3c3c0001 0",
               i_rvalid, i_rdata[31:0], d_rdata[31:0], d_gnt);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if (d_gnt !== 1'b1 || l2_add !== 26'h0000888 || l2_wr !== 1'b0)
      $display("FAIL b2b_dgrant: gnt=%b add=%h wr=%b want 1 0000888 0", d_gnt, l2_add, l2_wr);
    else pass_cnt++;
    d_req = 0; l2_ack = 1; l2_rdata = LINE5B;
    @(negedge clk);
    l2_ack = 0; l2_rvalid = 1;
    @(negedge clk);
    l2_rvalid = 0;
    tot_cnt++;
    if (d_rvalid !== 1'b1 || d_rdata !== LINE5B || i_rdata !== LINE5 || i_rvalid !== 1'b0)
      $display("FAIL b2b_dresp: rv=%b d=%h i=%h want 1 a5a50f0f 55551234",
               d_rvalid, d_rdata[31:0], i_rdata[31:0]);
    else pass_cnt++;
  endtask

  task automatic test_clear_mid_wait();
    i_req = 1; i_add = 26'h0000999;
    @(negedge clk);
    i_req = 0; l2_ack = 1;
    @(negedge clk);
    l2_ack = 0;
    clear = 1;
    #1;
    tot_cnt++;
    if (!outs_zero()) $display("FAIL clear_async: outputs nonzero during clear, want all 0");
    else pass_cnt++;
    #1 clear = 0;
    @(negedge clk);
    tot_cnt++;
    if (!outs_zero()) $display("FAIL clear_after: outputs nonzero after clear, want all 0");
    else pass_cnt++;
    l2_rvalid = 1; l2_rdata = LINE2;
    @(negedge clk);
    l2_rvalid = 0;
    tot_cnt++;
    if (proto_err !== 1'b1 || i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || i_rdata !== '0)
      $display("FAIL clear_proto: perr=%b irv=%b drv=%b want 1 0 0", proto_err, i_rvalid, d_rvalid);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if (proto_err !== 1'b1) $display("FAIL proto_sticky: perr=%b want 1", proto_err);
    else pass_cnt++;
  endtask

  task automatic test_counter_wrap();
    @(negedge clk);
    force dut.i_grants_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.i_grants_q;
    i_req = 1; i_add = 26'h0000ABC;
    @(negedge clk);
    tot_cnt++;
    if (i_gnt !== 1'b1 || i_grants !== 32'd0)
      $display("FAIL cnt_wrap: gnt=%b i_grants=%h want 1 00000000", i_gnt, i_grants);
    else pass_cnt++;
    i_req = 0; l2_ack = 1;
    @(negedge clk);
    l2_ack = 0; l2_rvalid = 1;
    @(negedge clk);
    l2_rvalid = 0;
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_alternation();
    test_writeback();
    test_back_to_back();
    test_clear_mid_wait();
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
